vector_mem_stage: RTL



---
 rtl/vmem_pkg.sv | 24 ++
 rtl/vmem_bank_ram.sv | 28 ++
 rtl/vector_mem_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared types and sizing helpers for the vector MEM stage and its scratchpad.
package vmem_pkg;

  localparam int unsigned DefLanes = 16;
  localparam int unsigned DefN     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRdTail,
    StDone
  } vmem_state_e;

  function automatic int unsigned beats_f(input int unsigned lanes, input int unsigned beat_lanes);
    return lanes / beat_lanes;
  endfunction

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int unsigned clog2_min1_f(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vmem_bank_ram.sv
// Single-port scratchpad bank: synchronous write, registered read with 1-cycle latency.
module vmem_bank_ram
  import vmem_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [clog2_min1_f(Depth)-1:0] addr_i,
  input  logic [Width-1:0]               wdata_i,
  output logic [Width-1:0]               rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_mem_stage.sv
// Vector MEM stage: splits each vector load/store into narrow scratchpad beats and
// reassembles load beats into the registered RDM result.
module vector_mem_stage
  import vmem_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned LANES      = DefLanes,
  parameter int unsigned BEAT_LANES = 4,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      MemWriteM,
  input  logic                      MemReadM,
  input  logic [N-1:0]              AddrM,
  input  logic [LANES-1:0][N-1:0]   writeDataM,
  output logic [LANES-1:0][N-1:0]   RDM,
  output logic                      StallM,
  output logic                      DoneM
);

  localparam int unsigned BEATS = beats_f(LANES, BEAT_LANES);
  localparam int unsigned AW    = clog2_min1_f(DEPTH);
  localparam int unsigned BeatW = clog2_min1_f(BEATS);
  localparam int unsigned RowW  = BEAT_LANES * N;
  localparam int unsigned Rows  = DEPTH * BEATS;
  localparam int unsigned RowAw = clog2_min1_f(Rows);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  vmem_state_e state_q, state_d;

  logic [BeatW-1:0]             beat_q, beat_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [BEATS-1:0][RowW-1:0]   wdata_q, wdata_d;
  logic [BEATS-1:0][RowW-1:0]   rdm_q, rdm_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [BeatW-1:0]             rd_beat_q, rd_beat_d;

  logic                         ram_we;
  logic                         rd_issue;
  logic [RowAw-1:0]             ram_addr;
  logic [RowW-1:0]              ram_rdata;

  logic unused_addr;
  assign unused_addr = ^AddrM;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE never resamples the still-present request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (MemWriteM) begin
          state_d = StWr;
        end else if (MemReadM) begin
          state_d = StRd;
        end
      end
      StWr:     if (beat_q == LastBeat) state_d = StDone;
      StRd:     if (beat_q == LastBeat) state_d = StRdTail;
      StRdTail: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    StallM   = 1'b0;
    DoneM    = 1'b0;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    unique case (state_q)
      StIdle:   StallM = MemWriteM | MemReadM;
      StWr: begin
        StallM = 1'b1;
        ram_we = ~RST;
      end
      StRd: begin
        StallM   = 1'b1;
        rd_issue = 1'b1;
      end
      StRdTail: StallM = 1'b1;
      StDone:   DoneM = 1'b1;
      default:  StallM = 1'b0;
    endcase
  end

  // Datapath next-state: request capture, beat stepping and RDM lane assembly.
  always_comb begin
    beat_d     = beat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdm_d      = rdm_q;
    rd_valid_d = rd_issue;
    rd_beat_d  = beat_q;

    if (state_q == StIdle && (MemWriteM || MemReadM)) begin
      addr_d = AddrM[AW-1:0];
      beat_d = '0;
      if (MemWriteM) begin
        wdata_d = writeDataM;
      end
    end

    if (ram_we || rd_issue) begin
      beat_d = beat_q + 1'b1;
    end

    // Read data for the beat issued last cycle is valid now.
    if (rd_valid_q) begin
      rdm_d[rd_beat_q] = ram_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdm_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_beat_q  <= '0;
    end else begin
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdm_q      <= rdm_d;
      rd_valid_q <= rd_valid_d;
      rd_beat_q  <= rd_beat_d;
    end
  end

  assign ram_addr = RowAw'(addr_q) * RowAw'(BEATS) + RowAw'(beat_q);

  vmem_bank_ram #(
    .Width (RowW),
    .Depth (Rows)
  ) u_bank_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q[beat_q]),
    .rdata_o (ram_rdata)
  );

  assign RDM = rdm_q;

endmodule
